sec_led_seq: RTL and testbench
==============================

SEC_LED_SEQ -- requirements
Module: sec_led_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 12_000_000, meaning the safe_clk cycles without a tick rising edge before loss is declared (1.5 s at 8 MHz; legal range >= 2).
REQ-002 SHALL have port safe_clk, input, 1 bit: the single clock, 8 MHz MMCM output.
REQ-003 SHALL have port safe_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port tick_in, input, 1 bit: 1 Hz symmetrical square wave from the upstream second counter, already synchronous to safe_clk.
REQ-005 SHALL have port run_en, input, 1 bit: 1 = count seconds, 0 = hold the displayed time.
REQ-006 SHALL have port clear, input, 1 bit: synchronous clear of the time, watchdog and loss flag.
REQ-007 SHALL have port sec_bcd, output, 8 bits: {tens[3:0], ones[3:0]} of seconds, 00-59.
REQ-008 SHALL have port min_bcd, output, 8 bits: {tens, ones} of minutes, 00-59.
REQ-009 SHALL have port led, output, 16 bits: equal to {min_bcd, sec_bcd}.
REQ-010 SHALL have port sec_pulse, output, 1 bit: high for one cycle per counted second.
REQ-011 SHALL have port tick_lost, output, 1 bit: sticky flag that the tick stopped arriving.

Function
REQ-012 SHALL register tick_in into tick_d; rise = tick_in & ~tick_d, evaluated every cycle in all states.
REQ-013 SHALL implement FSM states IDLE, RUN and LOST, all registered.
REQ-014 SHALL move IDLE->RUN when run_en=1 and clear=0, zeroing the watchdog on entry.
REQ-015 SHALL move RUN->IDLE when run_en=0, holding the time.
REQ-016 SHALL count rise only when the current state is RUN; a rise in the IDLE->RUN transition cycle is ignored.
REQ-017 SHALL, on a counted rise in cycle N, present the updated sec_bcd/min_bcd and sec_pulse=1 in cycle N+1 (1-cycle latency); sec_pulse SHALL be 0 otherwise.
REQ-018 SHALL increment BCD digit-wise: seconds ones 9->0 carries to tens; seconds 59->00 carries to minutes; 59:59 wraps to 00:00, with no overflow flag.
REQ-019 SHALL, in RUN, clear the watchdog (width $clog2(TIMEOUT_CYCLES)) on a counted rise and otherwise increment it.
REQ-020 SHALL, when the watchdog equals TIMEOUT_CYCLES-1 with no rise in RUN, go to LOST and set tick_lost=1 in the next cycle.
REQ-021 SHALL, on a rise in the same cycle as the timeout, count the rise, reset the watchdog and stay in RUN.
REQ-022 SHALL, in LOST, freeze the time and watchdog and ignore both rise and run_en.
REQ-023 SHALL, on clear=1, in the next cycle zero sec_bcd, min_bcd and the watchdog, set tick_lost=0 and sec_pulse=0, and go to RUN if run_en=1 else IDLE, from any state.
REQ-024 SHALL give clear priority over a rise and over a timeout in the same cycle.
REQ-025 SHALL keep the watchdog at 0 in IDLE.

Reset
REQ-026 SHALL, while safe_reset_n=0, asynchronously force state=IDLE, tick_d=0, sec_bcd=8'h00, min_bcd=8'h00, led=16'h0000, sec_pulse=0, tick_lost=0 and watchdog=0.
REQ-027 SHALL release reset synchronously: the first evaluation after deassertion is at the next safe_clk edge; a reset mid-count discards all time and flags.

Verification (sim with TIMEOUT_CYCLES=20, tick period 10 cycles)
REQ-028 SHALL check: reset, run_en=1, 3 tick rises -> sec_bcd=8'h03, three single-cycle sec_pulse, each 1 cycle after its rise.
REQ-029 SHALL check: preload by ticking to 59:59, then 1 rise -> led=16'h0000 next cycle; at 09->10 s, sec_bcd=8'h10.
REQ-030 SHALL check: tick held low 20 cycles in RUN -> tick_lost=1 and state LOST; further rises leave led unchanged; clear -> tick_lost=0, led=0, counting resumes.
REQ-031 SHALL check: run_en=0 for 3 rises -> time held and no sec_pulse; run_en=1 -> counting resumes from the held value.
REQ-032 SHALL check: clear and rise in the same cycle -> sec_bcd=8'h00 and sec_pulse=0 next cycle.
REQ-033 SHALL check: safe_reset_n asserted mid-cycle at 00:42 -> all outputs 0 immediately, before any clock edge.

Source files
------------

// File: rtl/sec_led_seq.sv
// +------------------------------------------------------------------------+
// | sec_led_seq: BCD mm:ss seconds sequencer driven by a 1 Hz tick, with  |
// | a tick-loss watchdog and LED mirror of the time.       Rev 1.0        |
// +------------------------------------------------------------------------+
`default_nettype none

module sec_led_seq #(
    parameter int TIMEOUT_CYCLES = 12_000_000
) (
    input  logic        safe_clk,
    input  logic        safe_reset_n,
    input  logic        tick_in,
    input  logic        run_en,
    input  logic        clear,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic [15:0] led,
    output logic        sec_pulse,
    output logic        tick_lost
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              tick_d_q, tick_d_d;
    logic [7:0]        sec_q, sec_d;
    logic [7:0]        min_q, min_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              sec_pulse_q, sec_pulse_d;
    logic              tick_lost_q, tick_lost_d;

    logic              rise;
    logic [15:0]       cnt_inc;

    // Digit-wise BCD increment of {min_tens, min_ones, sec_tens, sec_ones}; 59:59 wraps to 00:00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] s1, s10, m1, m10;
        s1  = t[3:0];
        s10 = t[7:4];
        m1  = t[11:8];
        m10 = t[15:12];
        if (s1 != 4'd9) begin
            s1 = s1 + 4'd1;
        end else begin
            s1 = 4'd0;
            if (s10 != 4'd5) begin
                s10 = s10 + 4'd1;
            end else begin
                s10 = 4'd0;
                if (m1 != 4'd9) begin
                    m1 = m1 + 4'd1;
                end else begin
                    m1 = 4'd0;
                    if (m10 != 4'd5) begin
                        m10 = m10 + 4'd1;
                    end else begin
                        m10 = 4'd0;
                    end
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign rise    = tick_in & ~tick_d_q;
    assign cnt_inc = bcd_inc({min_q, sec_q});

    always_comb begin
        tick_d_d    = tick_in;
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        wd_d        = wd_q;
        sec_pulse_d = 1'b0;
        tick_lost_d = tick_lost_q;

        if (clear) begin
            // Clear beats both a rise and a timeout in the same cycle.
            sec_d       = 8'h00;
            min_d       = 8'h00;
            wd_d        = '0;
            tick_lost_d = 1'b0;
            state_d     = run_en ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wd_d = '0;
                    if (run_en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rise) begin
                        {min_d, sec_d} = cnt_inc;
                        sec_pulse_d    = 1'b1;
                    end
                    if (!run_en) begin
                        state_d = ST_IDLE;
                        wd_d    = '0;
                    end else if (rise) begin
                        wd_d = '0;
                    end else if (wd_q == WD_MAX) begin
                        state_d     = ST_LOST;
                        tick_lost_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ST_LOST: begin
                    // Frozen until clear; rises and run_en are ignored.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            state_q     <= ST_IDLE;
            tick_d_q    <= 1'b0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            wd_q        <= '0;
            sec_pulse_q <= 1'b0;
            tick_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_d_q    <= tick_d_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            wd_q        <= wd_d;
            sec_pulse_q <= sec_pulse_d;
            tick_lost_q <= tick_lost_d;
        end
    end

    assign sec_bcd   = sec_q;
    assign min_bcd   = min_q;
    assign led       = {min_q, sec_q};
    assign sec_pulse = sec_pulse_q;
    assign tick_lost = tick_lost_q;

endmodule

`default_nettype wire

// File: tb/tb_sec_led_seq.sv
// +------------------------------------------------------------------------+
// | tb_sec_led_seq: self-checking bench for sec_led_seq (TIMEOUT=20).     |
// |                                                        Rev 1.0        |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_sec_led_seq;

    localparam int TO = 20;

    logic        safe_clk = 1'b0;
    logic        safe_reset_n;
    logic        tick_in;
    logic        run_en;
    logic        clear;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic [15:0] led;
    logic        sec_pulse;
    logic        tick_lost;

    sec_led_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .safe_clk    (safe_clk),
        .safe_reset_n(safe_reset_n),
        .tick_in     (tick_in),
        .run_en      (run_en),
        .clear       (clear),
        .sec_bcd     (sec_bcd),
        .min_bcd     (min_bcd),
        .led         (led),
        .sec_pulse   (sec_pulse),
        .tick_lost   (tick_lost)
    );

    always #5 safe_clk = ~safe_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: elapsed time kept as a plain seconds count, watchdog as a cycle count.
    localparam int M_IDLE = 0, M_RUN = 1, M_LOST = 2;
    int   m_mode;
    int   m_secs;
    int   m_wd;
    bit   m_lost;
    bit   m_pulse;
    bit   m_prev;

    typedef struct {
        logic       tick;
        logic       run;
        logic       clr;
        logic [7:0] sec;
        logic [7:0] mnt;
        logic       pulse;
        logic       lost;
    } vec_t;

    vec_t tbl [25];
    logic rnd_tick, rnd_run, rnd_clr;
    logic [15:0] led_hold;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_wd = 0; m_lost = 0; m_pulse = 0; m_prev = 0;
    endtask

    task automatic model_step(input logic t, input logic r, input logic c);
        bit rs;
        rs      = t && !m_prev;
        m_prev  = t;
        m_pulse = 0;
        if (c) begin
            m_secs = 0; m_wd = 0; m_lost = 0;
            m_mode = r ? M_RUN : M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_wd = 0;
            if (r) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (rs) begin
                m_secs  = (m_secs + 1) % 3600;
                m_pulse = 1;
            end
            if (!r) begin
                m_mode = M_IDLE; m_wd = 0;
            end else if (rs) begin
                m_wd = 0;
            end else if (m_wd == TO - 1) begin
                m_mode = M_LOST; m_lost = 1;
            end else begin
                m_wd = m_wd + 1;
            end
        end
    endtask

    task automatic model_compare();
        logic [7:0] es, em;
        es = to_bcd(m_secs % 60);
        em = to_bcd(m_secs / 60);
        check("model_sec", 32'(sec_bcd), 32'(es));
        check("model_min", 32'(min_bcd), 32'(em));
        check("model_led", 32'(led), 32'({em, es}));
        check("model_pulse", 32'(sec_pulse), 32'(m_pulse));
        check("model_lost", 32'(tick_lost), 32'(m_lost));
    endtask

    // Called at a falling edge: apply inputs, let one rising edge happen, compare at the next fall.
    task automatic drive(input logic t, input logic r, input logic c);
        tick_in = t; run_en = r; clear = c;
        @(posedge safe_clk);
        model_step(t, r, c);
        @(negedge safe_clk);
        model_compare();
    endtask

    task automatic one_rise();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0};

        // Reset state, visible before any clock edge.
        safe_reset_n = 1'b0;
        tick_in = 1'b0; run_en = 1'b0; clear = 1'b0;
        model_reset();
        #2;
        check("reset_led_async", 32'(led), 32'h0);
        check("reset_pulse", 32'(sec_pulse), 32'h0);
        check("reset_lost", 32'(tick_lost), 32'h0);
        @(negedge safe_clk);
        @(negedge safe_clk);
        check("reset_sec_held", 32'(sec_bcd), 32'h0);
        check("reset_min_held", 32'(min_bcd), 32'h0);
        safe_reset_n = 1'b1;

        // Directed table: counting, pulses, clear vs rise, hold, IDLE->RUN rise ignored.
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].tick, tbl[i].run, tbl[i].clr);
            check($sformatf("tbl%0d_sec", i), 32'(sec_bcd), 32'(tbl[i].sec));
            check($sformatf("tbl%0d_min", i), 32'(min_bcd), 32'(tbl[i].mnt));
            check($sformatf("tbl%0d_pulse", i), 32'(sec_pulse), 32'(tbl[i].pulse));
            check($sformatf("tbl%0d_lost", i), 32'(tick_lost), 32'(tbl[i].lost));
        end

        // 09 -> 10 digit carry, then 59:59 -> 00:00 wrap.
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) one_rise();
        check("carry_sec_10", 32'(sec_bcd), 32'h10);
        for (int i = 10; i < 3599; i++) one_rise();
        check("preload_5959", 32'(led), 32'h5959);
        drive(1'b1, 1'b1, 1'b0);
        check("wrap_led", 32'(led), 32'h0000);
        check("wrap_pulse", 32'(sec_pulse), 32'h1);

        // Rise landing exactly on the timeout cycle keeps RUN.
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("edge_rise_lost", 32'(tick_lost), 32'h0);
        check("edge_rise_sec", 32'(sec_bcd), 32'h02);

        // Tick loss after TO quiet cycles, frozen while lost, clear recovers.
        for (int i = 0; i < TO - 1; i++) drive(1'b0, 1'b1, 1'b0);
        check("lost_not_yet", 32'(tick_lost), 32'h0);
        drive(1'b0, 1'b1, 1'b0);
        check("lost_set", 32'(tick_lost), 32'h1);
        led_hold = led;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'(i % 2), 1'b0);
            drive(1'b0, 1'b1, 1'b0);
        end
        check("lost_led_frozen", 32'(led), 32'(led_hold));
        check("lost_still", 32'(tick_lost), 32'h1);
        drive(1'b0, 1'b1, 1'b1);
        check("clear_lost", 32'(tick_lost), 32'h0);
        check("clear_led", 32'(led), 32'h0);
        drive(1'b1, 1'b1, 1'b0);
        check("resume_sec", 32'(sec_bcd), 32'h01);

        // Asynchronous reset in the middle of a cycle at 00:42.
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 42; i++) one_rise();
        check("pre_reset_led", 32'(led), 32'h0042);
        @(posedge safe_clk);
        model_step(1'b0, 1'b1, 1'b0);
        #2;
        safe_reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_sec", 32'(sec_bcd), 32'h0);
        check("midreset_min", 32'(min_bcd), 32'h0);
        check("midreset_led", 32'(led), 32'h0);
        check("midreset_pulse", 32'(sec_pulse), 32'h0);
        check("midreset_lost", 32'(tick_lost), 32'h0);
        @(negedge safe_clk);
        safe_reset_n = 1'b1;

        // Randomized traffic against the reference model.
        rnd_tick = 1'b0; rnd_run = 1'b1; rnd_clr = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) rnd_tick = ~rnd_tick;
            if ($urandom_range(0, 59) == 0) rnd_run = ~rnd_run;
            rnd_clr = ($urandom_range(0, 199) == 0);
            drive(rnd_tick, rnd_run, rnd_clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
